// File: rtl/regfile_pkg.sv
// rtl/regfile_pkg.sv - shared types and defaults for the multi-port register file
package regfile_pkg;

    typedef enum logic [1:0] {RF_IDLE, RF_CLEAR, RF_DONE} rf_state_t;

    localparam int RF_DATA_WIDTH = 16;
    localparam int RF_NUM_REGS   = 8;

endpackage

// File: rtl/regfile_readport.sv
// rtl/regfile_readport.sv - one combinational read port with optional write forwarding
module regfile_readport
    import regfile_pkg::*;
#(
    parameter int DATA_WIDTH = RF_DATA_WIDTH,
    parameter int NUM_REGS   = RF_NUM_REGS,
    parameter int ADDR_WIDTH = $clog2(NUM_REGS),
    parameter int BYPASS     = 1
) (
    input  logic [NUM_REGS-1:0][DATA_WIDTH-1:0] regs,
    input  logic [ADDR_WIDTH-1:0]               readnum,
    input  logic                                bypass_en,
    input  logic [ADDR_WIDTH-1:0]               writenum,
    input  logic [DATA_WIDTH-1:0]               data_in,
    output logic [DATA_WIDTH-1:0]               data
);

    localparam logic [ADDR_WIDTH:0] REG_COUNT = (ADDR_WIDTH + 1)'(NUM_REGS);

    logic in_range;

    assign in_range = {1'b0, readnum} < REG_COUNT;

    // bypass_en already implies an accepted, in-range write
    always_comb begin
        data = '0;
        if (in_range) begin
            data = regs[readnum];
        end
        if (BYPASS != 0 && bypass_en && writenum == readnum) begin
            data = data_in;
        end
    end

endmodule

// File: rtl/regfile_multi.sv
// rtl/regfile_multi.sv - register file with one write port, two read ports and a sequenced bulk clear
module regfile_multi
    import regfile_pkg::*;
#(
    parameter int DATA_WIDTH = RF_DATA_WIDTH,
    parameter int NUM_REGS   = RF_NUM_REGS,
    parameter int ADDR_WIDTH = $clog2(NUM_REGS),
    parameter int BYPASS     = 1
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  write,
    input  logic [ADDR_WIDTH-1:0] writenum,
    input  logic [DATA_WIDTH-1:0] data_in,
    input  logic [ADDR_WIDTH-1:0] readnum_a,
    input  logic [ADDR_WIDTH-1:0] readnum_b,
    output logic [DATA_WIDTH-1:0] data_a,
    output logic [DATA_WIDTH-1:0] data_b,
    input  logic                  clear_req,
    output logic                  busy,
    output logic                  clear_done,
    output logic                  write_dropped
);

    localparam logic [ADDR_WIDTH:0]   REG_COUNT = (ADDR_WIDTH + 1)'(NUM_REGS);
    localparam logic [ADDR_WIDTH-1:0] LAST_REG  = ADDR_WIDTH'(NUM_REGS - 1);

    rf_state_t                          state;
    rf_state_t                          state_next;
    logic [ADDR_WIDTH-1:0]              cnt;
    logic [NUM_REGS-1:0][DATA_WIDTH-1:0] regs;
    logic                               write_ok;

    assign write_ok   = write && state == RF_IDLE && ({1'b0, writenum} < REG_COUNT);
    assign busy       = state != RF_IDLE;
    assign clear_done = state == RF_DONE;

    always_ff @(posedge clk) begin
        if (reset) begin
            state <= RF_IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next = state;
        case (state)
            RF_IDLE:  if (clear_req) state_next = RF_CLEAR;
            RF_CLEAR: if (cnt == LAST_REG) state_next = RF_DONE;
            RF_DONE:  state_next = RF_IDLE;
            default:  state_next = RF_IDLE;
        endcase
    end

    // Outside CLEAR the counter is held at 0 so a new sweep always starts at reg 0
    always_ff @(posedge clk) begin
        if (reset) begin
            regs          <= '0;
            cnt           <= '0;
            write_dropped <= 1'b0;
        end else begin
            write_dropped <= write && !write_ok;
            if (state == RF_CLEAR) begin
                regs[cnt] <= '0;
                cnt       <= (cnt == LAST_REG) ? '0 : cnt + ADDR_WIDTH'(1);
            end else begin
                cnt <= '0;
                if (write_ok) begin
                    regs[writenum] <= data_in;
                end
            end
        end
    end

    regfile_readport #(
        .DATA_WIDTH(DATA_WIDTH),
        .NUM_REGS  (NUM_REGS),
        .ADDR_WIDTH(ADDR_WIDTH),
        .BYPASS    (BYPASS)
    ) u_read_a (
        .regs     (regs),
        .readnum  (readnum_a),
        .bypass_en(write_ok),
        .writenum (writenum),
        .data_in  (data_in),
        .data     (data_a)
    );

    regfile_readport #(
        .DATA_WIDTH(DATA_WIDTH),
        .NUM_REGS  (NUM_REGS),
        .ADDR_WIDTH(ADDR_WIDTH),
        .BYPASS    (BYPASS)
    ) u_read_b (
        .regs     (regs),
        .readnum  (readnum_b),
        .bypass_en(write_ok),
        .writenum (writenum),
        .data_in  (data_in),
        .data     (data_b)
    );

endmodule

// File: doc/regfile_multi.md
Name: regfile_multi

Overview:
- Parametrised multi-port register file for the datapath.
- Stores NUM_REGS words of DATA_WIDTH bits, with one synchronous write port and two asynchronous read ports (A, B).
- Optional write-to-read bypass.
- A sequenced bulk-clear engine zeroes one register per cycle under a busy/done handshake.
- Sits between the instruction decoder and the ALU operand latches.

Parameters:
- DATA_WIDTH, 16, bits per register.
- NUM_REGS, 8, number of registers; need not be a power of two, must be 2 or more.
- ADDR_WIDTH, $clog2(NUM_REGS), width of all register-number ports.
- BYPASS, 1, 1 = a same-cycle write is forwarded to a matching read port; 0 = the read port returns the stored value.

Ports:
- clk  input  1  rising-edge clock.
- reset  input  1  synchronous, active-high reset.
- write  input  1  write request, sampled at the rising edge of clk.
- writenum  input  ADDR_WIDTH  target register of the write.
- data_in  input  DATA_WIDTH  write data.
- readnum_a  input  ADDR_WIDTH  read port A select.
- readnum_b  input  ADDR_WIDTH  read port B select.
- data_a  output  DATA_WIDTH  read port A data (combinational).
- data_b  output  DATA_WIDTH  read port B data (combinational).
- clear_req  input  1  start a bulk clear; level-sampled in IDLE.
- busy  output  1  high while a clear sequence is in progress.
- clear_done  output  1  one-cycle pulse when a clear completes.
- write_dropped  output  1  one-cycle pulse, registered, when a write was refused.

Behaviour:
- Reset, synchronous and active-high, has priority over everything:
  - all registers become 0; state IDLE; clear counter 0.
  - busy=0, clear_done=0, write_dropped=0.
  - Reset during CLEAR aborts the sequence; no clear_done pulse is issued.
- Write:
  - If write=1, state=IDLE and writenum<NUM_REGS, reg[writenum] takes data_in at the clock edge.
  - Latency is 1: a read in the next cycle returns the new value.
- Refused write: write=1 with state≠IDLE or writenum>=NUM_REGS. Contents are unchanged and write_dropped=1 in the following cycle.
- Reads:
  - data_x = reg[readnum_x], purely combinational.
  - readnum_x>=NUM_REGS returns 0.
  - Both ports may select the same register.
- Bypass (BYPASS=1): if write=1, state=IDLE, writenum<NUM_REGS and writenum==readnum_x, then data_x=data_in in the same cycle. This applies to both ports independently. With BYPASS=0 the old value is returned until the edge.
- Clear FSM, states IDLE, CLEAR, DONE:
  - IDLE: clear_req=1 → CLEAR, counter cnt=0. A write in that same cycle is still performed, because the state is IDLE at that edge.
  - CLEAR: each cycle reg[cnt]<=0, then cnt++. When cnt==NUM_REGS-1 (that register is zeroed on the same edge) → DONE. The sequence takes NUM_REGS cycles in CLEAR.
  - DONE: lasts one cycle, clear_done=1, then → IDLE.
  - busy=1 in both CLEAR and DONE.
  - clear_req is ignored while busy, and is not queued.
- Reads during CLEAR return current contents: already-swept registers read 0, unswept registers keep their old values. Bypass is disabled whenever busy=1.
- cnt is ADDR_WIDTH wide and never exceeds NUM_REGS-1, including when NUM_REGS is not a power of two.
- Simultaneous clear_req and write in IDLE: the write commits this edge, and the later sweep zeroes it.

Decomposition:
- Package regfile_pkg holds:
  - typedef enum logic [1:0] {RF_IDLE, RF_CLEAR, RF_DONE} rf_state_t.
  - Default constants RF_DATA_WIDTH=16 and RF_NUM_REGS=8.
- Sub-module regfile_readport, instantiated twice (ports A and B), parametrised by DATA_WIDTH, NUM_REGS and BYPASS. It takes the register array, readnum, the bypass enable, writenum and data_in, and produces data_x, including the out-of-range-returns-0 rule.
- The top level owns the storage, the write logic and the clear FSM.

Test Plan:
- Reset then idle read: reset=1 for 2 cycles, then read all addresses → data_a=data_b=16'h0000; busy=0, clear_done=0.
- Write then read: write reg3=16'hBEEF, next cycle readnum_a=3, readnum_b=3 → both 16'hBEEF. Write reg7=16'h1234, then read A=7, B=3 → 16'h1234 and 16'hBEEF.
- Bypass: BYPASS=1, reg2 holds 16'h0001; in the same cycle write reg2=16'hA5A5 with readnum_a=2 → data_a=16'hA5A5 before the edge. With BYPASS=0 → 16'h0001 before the edge, 16'hA5A5 after.
- Bulk clear: fill reg0..7 with 16'h1111..16'h8888; pulse clear_req.
  - busy is high for 9 cycles: 8 CLEAR + 1 DONE.
  - clear_done pulses exactly once, in the 9th cycle.
  - Mid-sweep (after 4 CLEAR cycles), reg0..3=0 and reg4..7 are unchanged.
  - Afterwards all registers read 0.
- Dropped write and out-of-range:
  - Write during CLEAR → no change, write_dropped=1 the next cycle.
  - With NUM_REGS=6, write writenum=7 → write_dropped=1, and reading readnum_a=7 returns 0.
- Reset mid-clear: assert reset in CLEAR cycle 3 → next cycle busy=0, all registers 0, and clear_done is never asserted.
